// File: rtl/car_mode_ctrl_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// car_mode_ctrl_pkg : shared encodings for the smart-car drive-mode controller
// Rev 1.0
// ---------------------------------------------------------------------------
package car_mode_ctrl_pkg;

    typedef enum logic [1:0] {
        AS_TRACK  = 2'b00,
        AS_HOLD   = 2'b01,
        AS_PARK   = 2'b10,
        AS_CRUISE = 2'b11
    } auto_sel_e;

    typedef enum logic [1:0] {
        OP_MANUAL = 2'b00,
        OP_SETSPD = 2'b01,
        OP_AUTO   = 2'b10,
        OP_CRUISE = 2'b11
    } cmd_op_e;

    typedef enum logic [2:0] {
        P_IDLE = 3'd0,
        P_REV1 = 3'd1,
        P_FWD  = 3'd2,
        P_REV2 = 3'd3,
        P_DONE = 3'd4
    } park_st_e;

    localparam int CMD_OP_HI = 7;
    localparam int CMD_OP_LO = 6;

    localparam logic [1:0] MAN_FWD     = 2'b01;
    localparam logic [1:0] MAN_REV     = 2'b10;
    localparam logic [1:0] STEER_RIGHT = 2'b01;
    localparam logic [1:0] STEER_LEFT  = 2'b10;

    localparam int MAN_SPEED     = 35;
    localparam int PARK_REV1_ADD = 8;
    localparam int PARK_LEG_ADD  = 5;

    localparam int DEG_CENTER_DEF = 95;
    localparam int DEG_LEFT_DEF   = 120;
    localparam int DEG_RIGHT_DEF  = 60;
    localparam int DEG_SIDE_L     = 110;
    localparam int DEG_SIDE_R     = 80;

endpackage
`default_nettype wire

// File: rtl/car_mode_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// car_mode_ctrl_if : sensor/command inputs and actuator outputs of the controller
// Rev 1.0
// ---------------------------------------------------------------------------
interface car_mode_ctrl_if #(
    parameter int SPD_W   = 8,
    parameter int DEG_W   = 9,
    parameter int N_TRACK = 2
);
    logic               cmd_valid;
    logic [7:0]         cmd_data;
    logic [7:0]         button;
    logic [7:0]         fwd_dist;
    logic [7:0]         back_dist;
    logic [1:0]         side_ir;
    logic [N_TRACK-1:0] track_ir;
    logic               park_req;
    logic               track_req;
    logic [SPD_W-1:0]   speed;
    logic [DEG_W-1:0]   degree;
    logic               direction;
    logic               beep_en;
    logic [2:0]         mode;
    logic               park_done;
    logic [SPD_W-1:0]   display;

    modport master (
        output cmd_valid, cmd_data, button, fwd_dist, back_dist, side_ir,
               track_ir, park_req, track_req,
        input  speed, degree, direction, beep_en, mode, park_done, display
    );

    modport slave (
        input  cmd_valid, cmd_data, button, fwd_dist, back_dist, side_ir,
               track_ir, park_req, track_req,
        output speed, degree, direction, beep_en, mode, park_done, display
    );
endinterface
`default_nettype wire

// File: rtl/car_mode_ctrl_tick_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tick_gen : one-cycle timebase pulse at TICK_HZ derived from CLK_HZ
// Rev 1.0
// ---------------------------------------------------------------------------
module tick_gen #(
    parameter int CLK_HZ  = 50_000_000,
    parameter int TICK_HZ = 8
) (
    input  logic clk_50M,
    input  logic rst_n,
    output logic tick_o
);
    localparam int DIV = ((CLK_HZ / TICK_HZ) < 2) ? 2 : (CLK_HZ / TICK_HZ);
    localparam int CW  = $clog2(DIV);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == CW'(DIV - 1));
        cnt_d  = tick_d ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o = tick_q;
endmodule
`default_nettype wire

// File: rtl/car_mode_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// car_mode_ctrl : command decode, boot/watchdog/park timers, park FSM, output mux
// Rev 1.0
// ---------------------------------------------------------------------------
module car_mode_ctrl
    import car_mode_ctrl_pkg::*;
#(
    parameter int SPD_W        = 8,
    parameter int DEG_W        = 9,
    parameter int N_TRACK      = 2,
    parameter int CLK_HZ       = 50_000_000,
    parameter int TICK_HZ      = 8,
    parameter int BOOT_TICKS   = 4,
    parameter int CMD_TIMEOUT  = 16,
    parameter int PARK_FWD_TK  = 11,
    parameter int DEG_CENTER   = DEG_CENTER_DEF,
    parameter int DEG_LEFT     = DEG_LEFT_DEF,
    parameter int DEG_RIGHT    = DEG_RIGHT_DEF,
    parameter int BASE_SPD_DEF = 15,
    parameter int STOP_DIST    = 10,
    parameter int PARK_ENTER   = 35,
    parameter int PARK_ALIGN   = 30,
    parameter int PARK_DONE    = 9
) (
    input  logic           clk_50M,
    input  logic           rst_n,
    car_mode_ctrl_if.slave bus
);
    localparam int TMR_W  = $clog2(PARK_FWD_TK + 1);
    localparam int WD_W   = $clog2(CMD_TIMEOUT + 1);
    localparam int BOOT_W = $clog2(BOOT_TICKS + 1);
    localparam int HALF   = N_TRACK / 2;

    function automatic logic [SPD_W-1:0] sat_add(input logic [SPD_W-1:0] a, input int b);
        logic [SPD_W:0] s;
        s = {1'b0, a} + (SPD_W+1)'(b);
        return s[SPD_W] ? {SPD_W{1'b1}} : s[SPD_W-1:0];
    endfunction

    logic             tick;
    logic             man_q, man_d;
    auto_sel_e        auto_q, auto_d;
    park_st_e         st_q, st_d, st_cur;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic [WD_W-1:0]  wd_cnt_q, wd_cnt_d;
    logic             wd_exp_q, wd_exp_d;
    logic [BOOT_W-1:0] boot_q, boot_d;
    logic [SPD_W-1:0] base_q, base_d, base_eff;
    logic             ovr_q, ovr_d;
    logic [1:0]       man_dir_q, man_dir_d, man_steer_q, man_steer_d;
    logic             prev_park_q, prev_track_q;
    logic [SPD_W-1:0] speed_q, speed_d;
    logic [DEG_W-1:0] degree_q, degree_d;
    logic             dir_q, dir_d, beep_q, beep_d, done_q, done_d;
    logic [SPD_W-1:0] display_q;
    logic             boot_act, park_edge, track_edge, mode_chg, park_mode;
    logic [3:0]       up_cnt, lo_cnt;

    tick_gen #(.CLK_HZ(CLK_HZ), .TICK_HZ(TICK_HZ)) u_tick (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .tick_o  (tick)
    );

    always_comb begin
        man_d       = man_q;
        auto_d      = auto_q;
        base_d      = base_q;
        ovr_d       = ovr_q;
        tmr_d       = tmr_q;
        wd_cnt_d    = wd_cnt_q;
        wd_exp_d    = wd_exp_q;
        boot_d      = boot_q;
        man_dir_d   = man_dir_q;
        man_steer_d = man_steer_q;
        speed_d     = '0;
        degree_d    = DEG_W'(DEG_CENTER);
        dir_d       = 1'b1;
        beep_d      = 1'b0;
        up_cnt      = '0;
        lo_cnt      = '0;

        boot_act   = (boot_q < BOOT_W'(BOOT_TICKS));
        park_edge  = bus.park_req & ~prev_park_q;
        track_edge = bus.track_req & ~prev_track_q;
        if (tick && boot_act) boot_d = boot_q + 1'b1;

        // A command in the same cycle as a sign edge swallows the edge.
        if (bus.cmd_valid) begin
            case (cmd_op_e'(bus.cmd_data[CMD_OP_HI:CMD_OP_LO]))
                OP_MANUAL: begin
                    man_d       = 1'b1;
                    man_dir_d   = bus.cmd_data[1:0];
                    man_steer_d = bus.cmd_data[3:2];
                end
                OP_SETSPD: begin
                    base_d = SPD_W'(bus.cmd_data[5:0]);
                    ovr_d  = 1'b1;
                end
                OP_AUTO: begin
                    man_d  = 1'b0;
                    auto_d = auto_sel_e'(bus.cmd_data[1:0]);
                end
                default: begin
                    man_d  = 1'b0;
                    auto_d = AS_CRUISE;
                end
            endcase
        end else if (!boot_act && !man_q) begin
            if (park_edge && !(st_q inside {P_REV1, P_FWD, P_REV2}) && !done_q)
                auto_d = AS_PARK;
            else if (track_edge)
                auto_d = AS_TRACK;
        end

        mode_chg  = ({man_d, auto_d} != {man_q, auto_q});
        park_mode = !man_d && (auto_d == AS_PARK);

        if (bus.cmd_valid)
            wd_cnt_d = '0;
        else if (man_q && tick && (wd_cnt_q != WD_W'(CMD_TIMEOUT)))
            wd_cnt_d = wd_cnt_q + 1'b1;
        if (bus.cmd_valid && (cmd_op_e'(bus.cmd_data[CMD_OP_HI:CMD_OP_LO]) == OP_MANUAL))
            wd_exp_d = 1'b0;
        else if (man_q && (wd_cnt_q == WD_W'(CMD_TIMEOUT)))
            wd_exp_d = 1'b1;

        if (tick && (tmr_q != '0)) tmr_d = tmr_q - 1'b1;

        // Entering park (or any mode change) restarts the sequence from idle.
        st_cur = (mode_chg || !park_mode) ? P_IDLE : st_q;
        st_d   = st_cur;
        case (st_cur)
            P_IDLE: st_d = park_mode ? P_REV1 : P_IDLE;
            P_REV1: if (bus.back_dist < 8'(PARK_ENTER)) begin
                        st_d  = P_FWD;
                        tmr_d = TMR_W'(PARK_FWD_TK);
                    end
            P_FWD:  if (tmr_q == '0) st_d = P_REV2;
            P_REV2: if (bus.back_dist < 8'(PARK_DONE)) st_d = P_DONE;
            P_DONE: st_d = P_DONE;
            default: st_d = P_IDLE;
        endcase
        done_d = (st_d == P_DONE);

        base_eff = ovr_d ? base_d : SPD_W'(bus.button);
        for (int k = 0; k < HALF; k++) begin
            lo_cnt = lo_cnt + 4'(bus.track_ir[k]);
            up_cnt = up_cnt + 4'(bus.track_ir[k + HALF]);
        end

        if (man_d) begin
            if (man_steer_d == STEER_RIGHT)     degree_d = DEG_W'(DEG_RIGHT);
            else if (man_steer_d == STEER_LEFT) degree_d = DEG_W'(DEG_LEFT);
            if (man_dir_d == MAN_FWD) speed_d = SPD_W'(MAN_SPEED);
            else if (man_dir_d == MAN_REV) begin
                speed_d = SPD_W'(MAN_SPEED);
                dir_d   = 1'b0;
            end
            if (wd_exp_d) speed_d = '0;
        end else begin
            case (auto_d)
                AS_TRACK: begin
                    speed_d = base_eff;
                    if (&bus.track_ir)      speed_d  = '0;
                    else if (up_cnt > lo_cnt) degree_d = DEG_W'(DEG_LEFT);
                    else if (lo_cnt > up_cnt) degree_d = DEG_W'(DEG_RIGHT);
                end
                AS_HOLD: speed_d = '0;
                AS_PARK: begin
                    case (st_d)
                        P_REV1: begin
                            speed_d  = sat_add(base_eff, PARK_REV1_ADD);
                            degree_d = DEG_W'(DEG_LEFT);
                            dir_d    = 1'b0;
                            beep_d   = 1'b1;
                        end
                        P_FWD: begin
                            speed_d  = sat_add(base_eff, PARK_LEG_ADD);
                            degree_d = DEG_W'(DEG_RIGHT);
                        end
                        P_REV2: begin
                            speed_d = sat_add(base_eff, PARK_LEG_ADD);
                            dir_d   = 1'b0;
                            beep_d  = 1'b1;
                            if (bus.back_dist >= 8'(PARK_ALIGN)) degree_d = DEG_W'(DEG_CENTER);
                            else if (!bus.side_ir[1])            degree_d = DEG_W'(DEG_SIDE_L);
                            else if (!bus.side_ir[0])            degree_d = DEG_W'(DEG_SIDE_R);
                        end
                        default: speed_d = '0;
                    endcase
                end
                default: speed_d = base_eff;
            endcase
        end

        if (boot_act) begin
            speed_d  = '0;
            degree_d = DEG_W'(DEG_CENTER);
        end
        // Front obstacle stop outranks every mode.
        if (dir_d && (bus.fwd_dist <= 8'(STOP_DIST))) speed_d = '0;
    end

    always_ff @(posedge clk_50M) begin
        if (!rst_n) begin
            man_q        <= 1'b0;
            auto_q       <= AS_CRUISE;
            st_q         <= P_IDLE;
            tmr_q        <= '0;
            wd_cnt_q     <= '0;
            wd_exp_q     <= 1'b0;
            boot_q       <= '0;
            base_q       <= SPD_W'(BASE_SPD_DEF);
            ovr_q        <= 1'b0;
            man_dir_q    <= '0;
            man_steer_q  <= '0;
            prev_park_q  <= 1'b1;
            prev_track_q <= 1'b1;
            speed_q      <= '0;
            degree_q     <= DEG_W'(DEG_CENTER);
            dir_q        <= 1'b1;
            beep_q       <= 1'b0;
            done_q       <= 1'b0;
            display_q    <= SPD_W'(BASE_SPD_DEF);
        end else begin
            man_q        <= man_d;
            auto_q       <= auto_d;
            st_q         <= st_d;
            tmr_q        <= tmr_d;
            wd_cnt_q     <= wd_cnt_d;
            wd_exp_q     <= wd_exp_d;
            boot_q       <= boot_d;
            base_q       <= base_d;
            ovr_q        <= ovr_d;
            man_dir_q    <= man_dir_d;
            man_steer_q  <= man_steer_d;
            prev_park_q  <= bus.park_req;
            prev_track_q <= bus.track_req;
            speed_q      <= speed_d;
            degree_q     <= degree_d;
            dir_q        <= dir_d;
            beep_q       <= beep_d;
            done_q       <= done_d;
            display_q    <= base_eff;
        end
    end

    assign bus.speed     = speed_q;
    assign bus.degree    = degree_q;
    assign bus.direction = dir_q;
    assign bus.beep_en   = beep_q;
    assign bus.mode      = {man_q, auto_q};
    assign bus.park_done = done_q;
    assign bus.display   = display_q;
endmodule
`default_nettype wire

// File: tb/tb_car_mode_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_car_mode_ctrl : directed self-checking bench, 1 tick = 10 clk
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_car_mode_ctrl;
    logic clk_50M = 1'b0;
    logic rst_n   = 1'b0;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_50M = ~clk_50M;

    car_mode_ctrl_if #(.SPD_W(8), .DEG_W(9), .N_TRACK(2)) bus2 ();
    car_mode_ctrl_if #(.SPD_W(8), .DEG_W(9), .N_TRACK(4)) bus4 ();

    car_mode_ctrl #(.N_TRACK(2), .CLK_HZ(50_000_000), .TICK_HZ(5_000_000)) dut (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .bus     (bus2)
    );

    car_mode_ctrl #(.N_TRACK(4), .CLK_HZ(50_000_000), .TICK_HZ(5_000_000)) dut4 (
        .clk_50M (clk_50M),
        .rst_n   (rst_n),
        .bus     (bus4)
    );

    logic [3:0] track4 = 4'b0000;
    assign bus4.cmd_valid = bus2.cmd_valid;
    assign bus4.cmd_data  = bus2.cmd_data;
    assign bus4.button    = bus2.button;
    assign bus4.fwd_dist  = bus2.fwd_dist;
    assign bus4.back_dist = bus2.back_dist;
    assign bus4.side_ir   = bus2.side_ir;
    assign bus4.track_ir  = track4;
    assign bus4.park_req  = bus2.park_req;
    assign bus4.track_req = bus2.track_req;

    task automatic check_eq(input string tag, input int unsigned act, input int unsigned exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) @(negedge clk_50M);
    endtask

    task automatic send_cmd(input logic [7:0] b);
        @(negedge clk_50M);
        bus2.cmd_valid = 1'b1;
        bus2.cmd_data  = b;
        @(negedge clk_50M);
        bus2.cmd_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        cyc(3);
        rst_n = 1'b1;
        cyc(55);
    endtask

    task automatic check_out(input string tag, input int spd, input int deg, input int dir, input int beep);
        check_eq({tag, "_speed"}, 32'(bus2.speed), spd);
        check_eq({tag, "_degree"}, 32'(bus2.degree), deg);
        check_eq({tag, "_dir"}, 32'(bus2.direction), dir);
        check_eq({tag, "_beep"}, 32'(bus2.beep_en), beep);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        bus2.cmd_valid = 1'b0; bus2.cmd_data = 8'h00; bus2.button = 8'd15;
        bus2.fwd_dist = 8'd50; bus2.back_dist = 8'd100; bus2.side_ir = 2'b11;
        bus2.track_ir = 2'b00; bus2.park_req = 1'b0; bus2.track_req = 1'b0;

        // reset values and boot hold
        cyc(3);
        check_out("rst", 0, 95, 1, 0);
        check_eq("rst_mode", 32'(bus2.mode), 3);
        check_eq("rst_done", 32'(bus2.park_done), 0);
        check_eq("rst_display", 32'(bus2.display), 15);
        rst_n = 1'b1;
        cyc(5);
        check_out("boot", 0, 95, 1, 0);
        cyc(50);
        check_out("cruise", 15, 95, 1, 0);

        // manual, safety stop, watchdog
        send_cmd(8'h05);
        check_out("man_fwd_r", 35, 60, 1, 0);
        check_eq("man_mode", 32'(bus2.mode), 7);
        bus2.fwd_dist = 8'd10; cyc(1);
        check_eq("safety_10", 32'(bus2.speed), 0);
        bus2.fwd_dist = 8'd11; cyc(1);
        check_eq("safety_11", 32'(bus2.speed), 35);
        cyc(100);
        check_eq("wd_before", 32'(bus2.speed), 35);
        cyc(80);
        check_eq("wd_expired", 32'(bus2.speed), 0);
        send_cmd(8'h0A);
        check_out("man_rev_l", 35, 120, 0, 0);
        bus2.fwd_dist = 8'd10; cyc(1);
        check_eq("safety_rev", 32'(bus2.speed), 35);
        bus2.fwd_dist = 8'd50;

        // set-speed and tracking
        send_cmd(8'h52);
        check_eq("display_18", 32'(bus2.display), 18);
        check_eq("setspd_mode", 32'(bus2.mode), 7);
        bus2.track_ir = 2'b10; track4 = 4'b1100;
        send_cmd(8'h80);
        check_out("track_10", 18, 120, 1, 0);
        check_eq("track_mode", 32'(bus2.mode), 0);
        check_eq("track4_1100", 32'(bus4.degree), 120);
        bus2.track_ir = 2'b01; track4 = 4'b0110; cyc(1);
        check_eq("track_01", 32'(bus2.degree), 60);
        check_eq("track4_0110", 32'(bus4.degree), 95);
        bus2.track_ir = 2'b11; cyc(1);
        check_out("track_11", 0, 95, 1, 0);
        bus2.track_ir = 2'b00; cyc(1);
        check_out("track_00", 18, 95, 1, 0);

        // park sequence from cruise with base 15
        do_reset();
        check_out("cruise2", 15, 95, 1, 0);
        bus2.park_req = 1'b1; cyc(2);
        check_out("p_rev1", 23, 120, 0, 1);
        check_eq("p_mode", 32'(bus2.mode), 2);
        bus2.back_dist = 8'd34; cyc(2);
        check_out("p_fwd", 20, 60, 1, 0);
        cyc(88);
        check_out("p_fwd_hold", 20, 60, 1, 0);
        cyc(30);
        check_out("p_rev2", 20, 95, 0, 1);
        bus2.back_dist = 8'd20; bus2.side_ir = 2'b01; cyc(1);
        check_eq("p_side_l", 32'(bus2.degree), 110);
        bus2.side_ir = 2'b10; cyc(1);
        check_eq("p_side_r", 32'(bus2.degree), 80);
        bus2.back_dist = 8'd9; cyc(1);
        check_eq("p_bd9_done", 32'(bus2.park_done), 0);
        check_eq("p_bd9_speed", 32'(bus2.speed), 20);
        bus2.back_dist = 8'd8; cyc(1);
        check_out("p_done", 0, 95, 1, 0);
        check_eq("p_done_flag", 32'(bus2.park_done), 1);

        // repeat edge while done, then leave by command
        bus2.park_req = 1'b0; cyc(2);
        bus2.park_req = 1'b1; cyc(3);
        check_eq("p_ignored_done", 32'(bus2.park_done), 1);
        check_eq("p_ignored_spd", 32'(bus2.speed), 0);
        send_cmd(8'hC0);
        check_eq("c0_done", 32'(bus2.park_done), 0);
        check_eq("c0_mode", 32'(bus2.mode), 3);
        check_eq("c0_speed", 32'(bus2.speed), 15);

        // track sign edge, then signs ignored in manual
        bus2.track_ir = 2'b01;
        bus2.track_req = 1'b1; cyc(1);
        check_eq("tsign_mode", 32'(bus2.mode), 0);
        check_eq("tsign_deg", 32'(bus2.degree), 60);
        bus2.track_req = 1'b0;
        send_cmd(8'h00);
        check_eq("man_stop_mode", 32'(bus2.mode), 4);
        check_eq("man_stop_spd", 32'(bus2.speed), 0);
        bus2.park_req = 1'b0; cyc(1);
        bus2.park_req = 1'b1; bus2.track_req = 1'b1; cyc(2);
        check_eq("man_sign_ign", 32'(bus2.mode), 4);
        bus2.track_req = 1'b0;

        // command beats simultaneous park edge
        send_cmd(8'hC0);
        bus2.park_req = 1'b0; cyc(1);
        bus2.park_req = 1'b1; bus2.cmd_valid = 1'b1; bus2.cmd_data = 8'h81;
        cyc(1);
        bus2.cmd_valid = 1'b0;
        check_eq("coll_mode", 32'(bus2.mode), 1);
        check_eq("coll_speed", 32'(bus2.speed), 0);
        cyc(2);
        check_eq("coll_mode2", 32'(bus2.mode), 1);

        // reset in the middle of the forward leg
        bus2.back_dist = 8'd100;
        send_cmd(8'h82);
        check_out("p2_rev1", 23, 120, 0, 1);
        bus2.back_dist = 8'd30; cyc(20);
        check_out("p2_fwd", 20, 60, 1, 0);
        rst_n = 1'b0; cyc(1);
        check_out("midrst", 0, 95, 1, 0);
        check_eq("midrst_mode", 32'(bus2.mode), 3);
        check_eq("midrst_done", 32'(bus2.park_done), 0);
        rst_n = 1'b1; cyc(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
`default_nettype wire
